admm_scheduler: RTL

ADMM_SCHEDULER -- requirements
Module: admm_scheduler

---
 rtl/admm_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/admm_scheduler.sv
// admm_scheduler: sequences the primal, slack and dual update stages of an ADMM solve.
// Each stage runs a four-phase handshake (start high until done high, start low until done
// low). After the dual stage, one check cycle bumps the iteration count and decides whether
// to stop (both residuals within tolerance, or the iteration limit reached) or loop again.
// A stage that fails to answer a handshake phase within STAGE_TIMEOUT cycles aborts the solve.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start                            level solve request, held until done
//   active_horizon, max_iter, tol    solve parameters, latched when the solve starts
//   primal/slack/dual_start, _done   per-stage handshakes
//   pri_res_u, pri_res_x             residuals from the dual stage
//   horizon_out                      latched horizon driven to all stages
//   busy, done, converged, error     solve status
//   iter_count                       completed iterations
module admm_scheduler #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned ITER_WIDTH    = 16,
   parameter int unsigned STAGE_TIMEOUT = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           active_horizon,
   input  logic [ITER_WIDTH-1:0] max_iter,
   input  logic [DATA_WIDTH-1:0] tol,
   output logic                  primal_start,
   input  logic                  primal_done,
   output logic                  slack_start,
   input  logic                  slack_done,
   output logic                  dual_start,
   input  logic                  dual_done,
   input  logic [DATA_WIDTH-1:0] pri_res_u,
   input  logic [DATA_WIDTH-1:0] pri_res_x,
   output logic [31:0]           horizon_out,
   output logic                  busy,
   output logic                  done,
   output logic                  converged,
   output logic                  error,
   output logic [ITER_WIDTH-1:0] iter_count
);

   localparam int unsigned TimerWidth = $clog2(STAGE_TIMEOUT + 1);

   typedef enum logic [3:0] {
      StIdle, StPrimalAssert, StPrimalRelease, StSlackAssert, StSlackRelease,
      StDualAssert, StDualRelease, StCheck, StFinish, StFail
   } state_e;

   state_e                  state_q, state_d;
   logic [TimerWidth-1:0]   timer_q;
   logic [31:0]             horizon_q, horizon_d;
   logic [ITER_WIDTH-1:0]   max_iter_q, max_iter_d;
   logic [DATA_WIDTH-1:0]   tol_q, tol_d;
   logic [ITER_WIDTH-1:0]   iter_q, iter_d;
   logic                    conv_q, conv_d;
   logic                    err_q, err_d;
   logic                    res_ok_q, res_ok_d;
   logic                    in_stage;
   logic                    timeout;

   assign in_stage = (state_q == StPrimalAssert) || (state_q == StPrimalRelease) ||
                     (state_q == StSlackAssert)  || (state_q == StSlackRelease)  ||
                     (state_q == StDualAssert)   || (state_q == StDualRelease);
   // Timer holds the number of cycles already spent in the current phase.
   assign timeout  = (timer_q == TimerWidth'(STAGE_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      horizon_d  = horizon_q;
      max_iter_d = max_iter_q;
      tol_d      = tol_q;
      iter_d     = iter_q;
      conv_d     = conv_q;
      err_d      = err_q;
      res_ok_d   = res_ok_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               horizon_d  = active_horizon;
               max_iter_d = max_iter;
               tol_d      = tol;
               iter_d     = '0;
               conv_d     = 1'b0;
               err_d      = 1'b0;
               state_d    = (max_iter == '0) ? StFinish : StPrimalAssert;
            end
         end
         StPrimalAssert: begin
            if (primal_done)  state_d = StPrimalRelease;
            else if (timeout) state_d = StFail;
         end
         StPrimalRelease: begin
            if (!primal_done) state_d = StSlackAssert;
            else if (timeout) state_d = StFail;
         end
         StSlackAssert: begin
            if (slack_done)   state_d = StSlackRelease;
            else if (timeout) state_d = StFail;
         end
         StSlackRelease: begin
            if (!slack_done)  state_d = StDualAssert;
            else if (timeout) state_d = StFail;
         end
         StDualAssert: begin
            if (dual_done) begin
               // Residuals are only guaranteed valid alongside the first dual_done.
               res_ok_d = (pri_res_u <= tol_q) && (pri_res_x <= tol_q);
               state_d  = StDualRelease;
            end else if (timeout) begin
               state_d = StFail;
            end
         end
         StDualRelease: begin
            if (!dual_done)   state_d = StCheck;
            else if (timeout) state_d = StFail;
         end
         StCheck: begin
            iter_d = iter_q + ITER_WIDTH'(1);
            if (res_ok_q) begin
               conv_d  = 1'b1;
               state_d = StFinish;
            end else if (iter_d == max_iter_q) begin
               state_d = StFinish;
            end else begin
               state_d = StPrimalAssert;
            end
         end
         StFinish, StFail: begin
            if (!start) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StFail) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         horizon_q  <= '0;
         max_iter_q <= '0;
         tol_q      <= '0;
         iter_q     <= '0;
         conv_q     <= 1'b0;
         err_q      <= 1'b0;
         res_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         horizon_q  <= horizon_d;
         max_iter_q <= max_iter_d;
         tol_q      <= tol_d;
         iter_q     <= iter_d;
         conv_q     <= conv_d;
         err_q      <= err_d;
         res_ok_q   <= res_ok_d;
         if (state_d != state_q) timer_q <= '0;
         else if (in_stage)      timer_q <= timer_q + TimerWidth'(1);
      end
   end

   // Starts decode from distinct states, so at most one can be high.
   assign primal_start = (state_q == StPrimalAssert);
   assign slack_start  = (state_q == StSlackAssert);
   assign dual_start   = (state_q == StDualAssert);
   assign busy         = in_stage || (state_q == StCheck);
   assign done         = (state_q == StFinish) || (state_q == StFail);
   assign horizon_out  = horizon_q;
   assign converged    = conv_q;
   assign error        = err_q;
   assign iter_count   = iter_q;

endmodule
